// File: rtl/seg_link_pkg.sv
// Shared constants for the serial 7-segment link receiver: active-low segment
// codes (dp in bit 7, g..a in bits 6..0) and word/frame geometry.
package seg_link_pkg;

    localparam int unsigned WORD_BITS = 16;
    localparam int unsigned DIGITS    = 8;
    localparam int unsigned CNT_W     = 5;

    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_A     = 8'h88;
    localparam logic [7:0] SEG_B     = 8'h83;
    localparam logic [7:0] SEG_C     = 8'hC6;
    localparam logic [7:0] SEG_D     = 8'hA1;
    localparam logic [7:0] SEG_E     = 8'h86;
    localparam logic [7:0] SEG_F     = 8'h8E;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

endpackage

// File: rtl/seg_pattern_decode.sv
// Maps a 7-segment pattern (active-low, dp ignored) back to its hex nibble,
// flagging the all-off blank pattern and anything that is not a hex glyph.
module seg_pattern_decode
    import seg_link_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] nibble,
    output logic       blank,
    output logic       invalid
);

    always_comb begin
        nibble  = 4'h0;
        blank   = 1'b0;
        invalid = 1'b0;
        unique case ({1'b1, seg})
            SEG_0:     nibble = 4'h0;
            SEG_1:     nibble = 4'h1;
            SEG_2:     nibble = 4'h2;
            SEG_3:     nibble = 4'h3;
            SEG_4:     nibble = 4'h4;
            SEG_5:     nibble = 4'h5;
            SEG_6:     nibble = 4'h6;
            SEG_7:     nibble = 4'h7;
            SEG_8:     nibble = 4'h8;
            SEG_9:     nibble = 4'h9;
            SEG_A:     nibble = 4'hA;
            SEG_B:     nibble = 4'hB;
            SEG_C:     nibble = 4'hC;
            SEG_D:     nibble = 4'hD;
            SEG_E:     nibble = 4'hE;
            SEG_F:     nibble = 4'hF;
            SEG_BLANK: blank  = 1'b1;
            default:   invalid = 1'b1;
        endcase
    end

endmodule

// File: rtl/seg_link_receiver.sv
// Receiver for the segment_scan serial link: deserialises 74HC595 words and
// rebuilds 8-digit frames. Define SEG_LINK_RX_STATS_EN for frame/error counters.
module seg_link_receiver
    import seg_link_pkg::*;
#(
    parameter int unsigned SYNC_STAGES  = 2,
    parameter int unsigned LINK_TIMEOUT = 1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        seg_rck,
    input  logic        seg_sck,
    input  logic        seg_din,
    output logic [31:0] digit_dat,
    output logic [7:0]  digit_en,
    output logic [7:0]  dot_en,
    output logic        frame_valid,
    output logic        err_pulse,
    output logic        link_up
`ifdef SEG_LINK_RX_STATS_EN
    ,
    output logic [15:0] frame_cnt,
    output logic [15:0] err_cnt
`endif
);

    localparam int unsigned TO_W = $clog2(LINK_TIMEOUT + 1);
    localparam int unsigned TOP  = SYNC_STAGES - 1;

    logic [SYNC_STAGES-1:0] sck_sync, rck_sync, din_sync;
    logic                   sck_hist, rck_hist;
    logic [WORD_BITS-1:0]   sr;
    logic [CNT_W-1:0]       bit_cnt;
    logic [31:0]            shadow_dat;
    logic [7:0]             shadow_lit, shadow_dot, seen;
    logic [TO_W-1:0]        to_cnt;

    logic                 sck_rise_c, rck_rise_c;
    logic [WORD_BITS-1:0] word_c;
    logic [CNT_W-1:0]     cnt_next_c;
    logic [7:0]           seg_c, sel_n_c;
    logic [2:0]           idx_c;
    logic                 onehot_c, word_ok_c, err_c, commit_c;
    logic [3:0]           nibble_c;
    logic                 blank_c, invalid_c;

    seg_pattern_decode u_decode (
        .seg     (seg_c[6:0]),
        .nibble  (nibble_c),
        .blank   (blank_c),
        .invalid (invalid_c)
    );

    // Word capture: a shift in the same cycle as the latch is folded in first.
    always_comb begin
        sck_rise_c = sck_sync[TOP] & ~sck_hist;
        rck_rise_c = rck_sync[TOP] & ~rck_hist;
        word_c     = sck_rise_c ? {sr[WORD_BITS-2:0], din_sync[TOP]} : sr;
        cnt_next_c = (sck_rise_c && bit_cnt != '1) ? bit_cnt + CNT_W'(1) : bit_cnt;
        seg_c      = word_c[15:8];
        sel_n_c    = ~word_c[7:0];
        onehot_c   = (sel_n_c != 8'h00) && ((sel_n_c & (sel_n_c - 8'h01)) == 8'h00);
        idx_c      = 3'd0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (sel_n_c[i]) idx_c = 3'(i);
        end
        word_ok_c  = rck_rise_c && (cnt_next_c == CNT_W'(WORD_BITS)) && onehot_c && !invalid_c;
        err_c      = rck_rise_c && !word_ok_c;
        commit_c   = word_ok_c && (idx_c == 3'd0) && (seen != 8'h00);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sck_sync    <= '0;
            rck_sync    <= '0;
            din_sync    <= '0;
            sck_hist    <= 1'b0;
            rck_hist    <= 1'b0;
            sr          <= '0;
            bit_cnt     <= '0;
            shadow_dat  <= '0;
            shadow_lit  <= '0;
            shadow_dot  <= '0;
            seen        <= '0;
            to_cnt      <= '0;
            digit_dat   <= '0;
            digit_en    <= '0;
            dot_en      <= '0;
            frame_valid <= 1'b0;
            err_pulse   <= 1'b0;
            link_up     <= 1'b0;
        end else begin
            sck_sync    <= {sck_sync[SYNC_STAGES-2:0], seg_sck};
            rck_sync    <= {rck_sync[SYNC_STAGES-2:0], seg_rck};
            din_sync    <= {din_sync[SYNC_STAGES-2:0], seg_din};
            sck_hist    <= sck_sync[TOP];
            rck_hist    <= rck_sync[TOP];
            frame_valid <= 1'b0;
            err_pulse   <= err_c;

            if (sck_rise_c) sr <= word_c;
            bit_cnt <= rck_rise_c ? '0 : cnt_next_c;

            // Link watchdog; a commit in the same cycle always clears it first.
            if (word_ok_c) begin
                to_cnt <= '0;
            end else if (to_cnt != TO_W'(LINK_TIMEOUT)) begin
                to_cnt <= to_cnt + TO_W'(1);
            end else begin
                link_up  <= 1'b0;
                digit_en <= '0;
            end

            if (commit_c) begin
                digit_dat   <= shadow_dat;
                digit_en    <= seen & shadow_lit;
                dot_en      <= seen & shadow_dot;
                frame_valid <= 1'b1;
                link_up     <= 1'b1;
            end

            if (word_ok_c) begin
                seen                            <= (commit_c ? 8'h00 : seen) | (8'h01 << idx_c);
                shadow_dat[{idx_c, 2'b00} +: 4] <= nibble_c;
                shadow_lit[idx_c]               <= ~blank_c;
                shadow_dot[idx_c]               <= ~seg_c[7];
            end
        end
    end

`ifdef SEG_LINK_RX_STATS_EN
    // Saturating link statistics.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt <= '0;
            err_cnt   <= '0;
        end else begin
            if (commit_c && frame_cnt != 16'hFFFF) frame_cnt <= frame_cnt + 16'd1;
            if (err_c && err_cnt != 16'hFFFF)      err_cnt   <= err_cnt + 16'd1;
        end
    end
`endif

endmodule
